// File: rtl/univ_shift_reg_if.sv
// Port bundle for univ_shift_reg: load/mode/data/serial-in toward the register,
// parallel view, serial out and frame status back.
interface univ_shift_reg_if #(
  parameter int WIDTH = 4
);
  logic             ld_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] in_i;
  logic             sin_i;
  logic [WIDTH-1:0] out_o;
  logic             sout_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output ld_i, mode_i, in_i, sin_i,
    input  out_o, sout_o, busy_o, done_o
  );

  modport slave (
    input  ld_i, mode_i, in_i, sin_i,
    output out_o, sout_o, busy_o, done_o
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: PIPO, PISO-right, PISO-left and continuous SIPO with busy/done.
// Define UNIV_SHREG_PARITY_EN to append an even-parity bit to every PISO frame.
//
//   state   | meaning
//   IDLE    | holding shreg, no frame in progress
//   SHIFT   | PISO frame, one data bit per cycle on sout
//   COLLECT | SIPO, shifting sin in continuously, done every WIDTH bits
//   PARITY  | (parity build only) parity bit on sout after the data bits
module univ_shift_reg #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  univ_shift_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_PIPO   = 2'b00,
    MODE_PISO_R = 2'b01,
    MODE_PISO_L = 2'b10,
    MODE_SIPO   = 2'b11
  } mode_e;

`ifdef UNIV_SHREG_PARITY_EN
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHIFT   = 2'b01,
    COLLECT = 2'b10,
    PARITY  = 2'b11
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHIFT   = 2'b01,
    COLLECT = 2'b10
  } state_e;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  mode_e            mode_q,  mode_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             done_q,  done_d;
`ifdef UNIV_SHREG_PARITY_EN
  logic             par_q,   par_d;
`endif

  logic [WIDTH-1:0] shr_right;
  logic [WIDTH-1:0] shr_left;

  assign shr_right = {bus.sin_i, shreg_q[WIDTH-1:1]};
  assign shr_left  = {shreg_q[WIDTH-2:0], bus.sin_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_PIPO;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef UNIV_SHREG_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef UNIV_SHREG_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef UNIV_SHREG_PARITY_EN
    par_d   = par_q;
`endif

    // A load overrides everything, including the final shift of a frame.
    if (bus.ld_i) begin
      mode_d = mode_e'(bus.mode_i);
      cnt_d  = '0;
      case (mode_e'(bus.mode_i))
        MODE_PIPO: begin
          shreg_d = bus.in_i;
          state_d = IDLE;
        end
        MODE_PISO_R, MODE_PISO_L: begin
          shreg_d = bus.in_i;
          state_d = SHIFT;
`ifdef UNIV_SHREG_PARITY_EN
          par_d   = ^bus.in_i;
`endif
        end
        default: begin
          shreg_d = '0;
          state_d = COLLECT;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
        end
        SHIFT: begin
          shreg_d = (mode_q == MODE_PISO_L) ? shr_left : shr_right;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
`ifdef UNIV_SHREG_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
`ifdef UNIV_SHREG_PARITY_EN
        PARITY: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`endif
        COLLECT: begin
          shreg_d = shr_right;
          if (cnt_q == LAST_CNT) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.sout_o = 1'b0;
    if (state_q == SHIFT) begin
      bus.sout_o = (mode_q == MODE_PISO_L) ? shreg_q[WIDTH-1] : shreg_q[0];
    end
`ifdef UNIV_SHREG_PARITY_EN
    if (state_q == PARITY) begin
      bus.sout_o = par_q;
    end
`endif
  end

  assign bus.out_o  = shreg_q;
  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=4): expected cycle results are queued at drive
// time and popped/compared one time unit after the following rising edge.
module tb_univ_shift_reg;

  localparam int WIDTH = 4;

  typedef struct {
    string      tag;
    logic [3:0] out;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  univ_shift_reg_if #(.WIDTH(WIDTH)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      cmp({e.tag, ".out"},  bus.out_o,           e.out);
      cmp({e.tag, ".sout"}, {3'b000, bus.sout_o}, {3'b000, e.sout});
      cmp({e.tag, ".busy"}, {3'b000, bus.busy_o}, {3'b000, e.busy});
      cmp({e.tag, ".done"}, {3'b000, bus.done_o}, {3'b000, e.done});
    end
  endtask

  task automatic push(input string tag, input logic [3:0] o, input logic s,
                      input logic b, input logic d);
    exp_t e;
    e.tag = tag; e.out = o; e.sout = s; e.busy = b; e.done = d;
    exp_q.push_back(e);
  endtask

  // Drive inputs for one edge, queue what the next cycle must show, then check it.
  task automatic step(input logic ld, input logic [1:0] mode, input logic [3:0] din,
                      input logic s, input string tag, input logic [3:0] e_out,
                      input logic e_sout, input logic e_busy, input logic e_done);
    bus.ld_i   = ld;
    bus.mode_i = mode;
    bus.in_i   = din;
    bus.sin_i  = s;
    push(tag, e_out, e_sout, e_busy, e_done);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.ld_i = 1'b0; bus.mode_i = 2'b00; bus.in_i = 4'h0; bus.sin_i = 1'b0;
    #3;
    push("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // PIPO
    step(1, 2'b00, 4'hC, 0, "pipo",      4'hC, 0, 0, 0);
    step(0, 2'b00, 4'h0, 1, "pipo_hold", 4'hC, 0, 0, 0);

    // PISO-right 4'hC, fill 0
    step(1, 2'b01, 4'hC, 0, "pisor_b0", 4'hC, 0, 1, 0);
    step(0, 2'b00, 4'h0, 0, "pisor_b1", 4'h6, 0, 1, 0);
    step(0, 2'b00, 4'h0, 0, "pisor_b2", 4'h3, 1, 1, 0);
    step(0, 2'b00, 4'h0, 0, "pisor_b3", 4'h1, 1, 1, 0);
`ifdef UNIV_SHREG_PARITY_EN
    step(0, 2'b00, 4'h0, 0, "pisor_par", 4'h0, 0, 1, 0);
`endif
    step(0, 2'b00, 4'h0, 0, "pisor_done", 4'h0, 0, 0, 1);
    step(0, 2'b00, 4'h0, 0, "pisor_idle", 4'h0, 0, 0, 0);

    // PISO-left 4'h5, fill 1
    step(1, 2'b10, 4'h5, 1, "pisol_b0", 4'h5, 0, 1, 0);
    step(0, 2'b00, 4'h0, 1, "pisol_b1", 4'hB, 1, 1, 0);
    step(0, 2'b00, 4'h0, 1, "pisol_b2", 4'h7, 0, 1, 0);
    step(0, 2'b00, 4'h0, 1, "pisol_b3", 4'hF, 1, 1, 0);
`ifdef UNIV_SHREG_PARITY_EN
    step(0, 2'b00, 4'h0, 1, "pisol_par", 4'hF, 0, 1, 0);
`endif
    step(0, 2'b00, 4'h0, 1, "pisol_done", 4'hF, 0, 0, 1);
    step(0, 2'b00, 4'h0, 1, "pisol_idle", 4'hF, 0, 0, 0);

    // SIPO, two consecutive words
    step(1, 2'b11, 4'h9, 1, "sipo_ld", 4'h0, 0, 1, 0);
    step(0, 2'b00, 4'h0, 1, "sipo_a1", 4'h8, 0, 1, 0);
    step(0, 2'b00, 4'h0, 0, "sipo_a2", 4'h4, 0, 1, 0);
    step(0, 2'b00, 4'h0, 1, "sipo_a3", 4'hA, 0, 1, 0);
    step(0, 2'b00, 4'h0, 1, "sipo_a4", 4'hD, 0, 1, 1);
    step(0, 2'b00, 4'h0, 0, "sipo_b1", 4'h6, 0, 1, 0);
    step(0, 2'b00, 4'h0, 0, "sipo_b2", 4'h3, 0, 1, 0);
    step(0, 2'b00, 4'h0, 0, "sipo_b3", 4'h1, 0, 1, 0);
    step(0, 2'b00, 4'h0, 1, "sipo_b4", 4'h8, 0, 1, 1);

    // Abort a PISO frame after two bits with a PIPO load
    step(1, 2'b01, 4'hF, 0, "abort_ld",   4'hF, 1, 1, 0);
    step(0, 2'b00, 4'h0, 0, "abort_b1",   4'h7, 1, 1, 0);
    step(1, 2'b00, 4'h3, 0, "abort_pipo", 4'h3, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b00, 4'h0, 0, "abort_idle", 4'h3, 0, 0, 0);
    end

    // Load coinciding with the final shift wins
    step(1, 2'b01, 4'hC, 0, "race_ld", 4'hC, 0, 1, 0);
    step(0, 2'b00, 4'h0, 0, "race_b1", 4'h6, 0, 1, 0);
    step(0, 2'b00, 4'h0, 0, "race_b2", 4'h3, 1, 1, 0);
    step(0, 2'b00, 4'h0, 0, "race_b3", 4'h1, 1, 1, 0);
`ifdef UNIV_SHREG_PARITY_EN
    step(0, 2'b00, 4'h0, 0, "race_b4", 4'h0, 0, 1, 0);
`endif
    step(1, 2'b00, 4'h9, 0, "race_pipo", 4'h9, 0, 0, 0);
    step(0, 2'b00, 4'h0, 0, "race_idle", 4'h9, 0, 0, 0);

    // Reset mid-frame takes effect before the next edge
    step(1, 2'b01, 4'hA, 0, "rstmid_ld", 4'hA, 0, 1, 0);
    step(0, 2'b00, 4'h0, 0, "rstmid_b1", 4'h5, 1, 1, 0);
    rst = 1'b1;
    #1;
    push("rstmid_async", 4'h0, 0, 0, 0);
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    step(0, 2'b00, 4'h0, 0, "rstmid_after1", 4'h0, 0, 0, 0);
    step(0, 2'b00, 4'h0, 0, "rstmid_after2", 4'h0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
